// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 convolution window controller:
// controller states, kernel codes, switch decode values and image defaults.
package conv_pkg;

    localparam int IMG_W_DEF = 640;
    localparam int IMG_H_DEF = 480;
    localparam int AW_DEF    = 10;
    localparam int ROW_W     = 10;
    localparam int SW_W      = 18;

    // Whole-bank switch patterns that select a filter; anything else is passthrough.
    localparam logic [SW_W-1:0] SW_SHARP = 18'd1;
    localparam logic [SW_W-1:0] SW_GAUSS = 18'd3;
    localparam logic [SW_W-1:0] SW_RIDGE = 18'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_RUN,
        ST_EOL,
        ST_FLUSH,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        KSEL_PASS  = 2'd0,
        KSEL_SHARP = 2'd1,
        KSEL_GAUSS = 2'd2,
        KSEL_RIDGE = 2'd3
    } kernel_e;

    function automatic kernel_e sw_to_kernel(input logic [SW_W-1:0] sw);
        kernel_e k;
        case (sw)
            SW_SHARP: k = KSEL_SHARP;
            SW_GAUSS: k = KSEL_GAUSS;
            SW_RIDGE: k = KSEL_RIDGE;
            default:  k = KSEL_PASS;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/conv_window_ctrl_if.sv
// Pixel-in / window-out handshake bundle of the window controller.
// The slave modport is the controller's view, master is the source/sink view.
interface conv_window_ctrl_if
    import conv_pkg::*;
#(
    parameter int AW = AW_DEF
);

    logic             in_valid;
    logic             in_sof;
    logic             in_ready;
    logic             win_valid;
    logic [AW-1:0]    win_x;
    logic [ROW_W-1:0] win_y;
    logic             win_border;

    modport master (
        output in_valid,
        output in_sof,
        input  in_ready,
        input  win_valid,
        input  win_x,
        input  win_y,
        input  win_border
    );

    modport slave (
        input  in_valid,
        input  in_sof,
        output in_ready,
        output win_valid,
        output win_x,
        output win_y,
        output win_border
    );

endinterface

// File: rtl/conv_xy_counter.sv
// Column/row position counter for the raster walk. Clear restarts at the
// origin (optionally already stepped to column 1 for the pixel taken that
// cycle); row advance also returns the column to 0.
module conv_xy_counter
    import conv_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_col_en,
    input  logic             i_row_en,
    output logic [AW-1:0]    o_col,
    output logic [ROW_W-1:0] o_row,
    output logic             o_eol,
    output logic             o_eof
);

    logic [AW-1:0]    r_col;
    logic [ROW_W-1:0] r_row;

    // Position update; clear wins over row advance, which wins over column step.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_clear) begin
            r_col <= i_col_en ? AW'(1) : '0;
            r_row <= '0;
        end else if (i_row_en) begin
            r_col <= '0;
            r_row <= r_row + ROW_W'(1);
        end else if (i_col_en) begin
            r_col <= r_col + AW'(1);
        end
    end

    assign o_col = r_col;
    assign o_row = r_row;
    assign o_eol = (r_col == AW'(IMG_W - 1));
    assign o_eof = (r_row == ROW_W'(IMG_H - 1));

endmodule

// File: rtl/conv_window_ctrl.sv
// Sequences the 3x3 convolution datapath over a raster pixel stream: tracks
// the input position, drives the two line-buffer ports and emits one window
// per pixel, one cycle after the line-buffer read it depends on. Frames need
// IMG_W >= 2 and IMG_H >= 2 for a sensible window pattern.
module conv_window_ctrl
    import conv_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [SW_W-1:0]   SW,
    conv_window_ctrl_if.slave bus,
    output logic [AW-1:0]     lb_wraddr,
    output logic [AW-1:0]     lb_rdaddr,
    output logic              lb_wren,
    output logic              lb_sel,
    output logic [1:0]        kernel_sel,
    output logic              frame_done,
    output logic              sync_err
);

    state_e           r_state;
    state_e           w_next;

    logic [AW-1:0]    w_col;
    logic [ROW_W-1:0] w_row;
    logic             w_eol;
    logic             w_eof;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_start;
    logic             w_restart;
    logic             w_frame_pix;

    logic             w_clear;
    logic             w_col_en;
    logic             w_row_en;
    logic             w_toggle;
    logic             w_emit;
    logic [AW-1:0]    w_emit_x;
    logic [ROW_W-1:0] w_emit_y;

    logic             r_win_valid;
    logic [AW-1:0]    r_win_x;
    logic [ROW_W-1:0] r_win_y;
    logic             r_win_border;
    kernel_e          r_kernel;
    logic             r_lb_sel;
    logic             r_frame_done;
    logic             r_sync_err;

    function automatic logic is_border(input logic [AW-1:0] x, input logic [ROW_W-1:0] y);
        return (x == '0) || (x == AW'(IMG_W - 1)) || (y == '0) || (y == ROW_W'(IMG_H - 1));
    endfunction

    conv_xy_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .AW    (AW)
    ) u_xy (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_clear),
        .i_col_en (w_col_en),
        .i_row_en (w_row_en),
        .o_col    (w_col),
        .o_row    (w_row),
        .o_eol    (w_eol),
        .o_eof    (w_eof)
    );

    // Input is stalled only while the controller is producing windows on its own.
    assign w_in_ready  = (r_state != ST_EOL) && (r_state != ST_FLUSH);
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_start     = w_accept && bus.in_sof;
    assign w_restart   = w_start && ((r_state == ST_FILL) || (r_state == ST_RUN));
    assign w_frame_pix = w_accept && (bus.in_sof || (r_state == ST_FILL) || (r_state == ST_RUN));

    assign bus.in_ready = w_in_ready;
    assign lb_wren      = w_frame_pix;
    assign lb_wraddr    = w_start ? '0 : w_col;
    assign lb_rdaddr    = w_start ? '0 : w_col;

    // Next state, counter control and the window to be launched this cycle.
    always_comb begin
        w_next   = r_state;
        w_clear  = 1'b0;
        w_col_en = 1'b0;
        w_row_en = 1'b0;
        w_toggle = 1'b0;
        w_emit   = 1'b0;
        w_emit_x = '0;
        w_emit_y = '0;
        if (w_start) begin
            w_clear  = 1'b1;
            w_col_en = 1'b1;
            w_next   = (IMG_H > 1) ? ST_FILL : ST_RUN;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_next = ST_IDLE;
                end
                ST_DONE: begin
                    w_next = ST_IDLE;
                end
                ST_FILL: begin
                    if (w_accept) begin
                        if (w_eol) begin
                            w_row_en = 1'b1;
                            w_toggle = 1'b1;
                            w_next   = ST_RUN;
                        end else begin
                            w_col_en = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_accept) begin
                        if (w_col != '0) begin
                            w_emit   = 1'b1;
                            w_emit_x = w_col - AW'(1);
                            w_emit_y = w_row - ROW_W'(1);
                        end
                        if (w_eol) begin
                            w_next = ST_EOL;
                        end else begin
                            w_col_en = 1'b1;
                        end
                    end
                end
                ST_EOL: begin
                    w_emit   = 1'b1;
                    w_emit_x = AW'(IMG_W - 1);
                    w_emit_y = w_row - ROW_W'(1);
                    w_row_en = 1'b1;
                    w_toggle = 1'b1;
                    w_next   = w_eof ? ST_FLUSH : ST_RUN;
                end
                ST_FLUSH: begin
                    w_emit   = 1'b1;
                    w_emit_x = w_col;
                    w_emit_y = ROW_W'(IMG_H - 1);
                    if (w_eol) begin
                        w_next = ST_DONE;
                    end else begin
                        w_col_en = 1'b1;
                    end
                end
                default: begin
                    w_next = ST_IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Window outputs lag the accept cycle by one to line up with the RAM read.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_win_valid  <= 1'b0;
            r_win_x      <= '0;
            r_win_y      <= '0;
            r_win_border <= 1'b0;
        end else begin
            r_win_valid <= w_emit;
            if (w_emit) begin
                r_win_x      <= w_emit_x;
                r_win_y      <= w_emit_y;
                r_win_border <= is_border(w_emit_x, w_emit_y);
            end
        end
    end

    // Per-frame controls: kernel latch at frame start, buffer swap per row, status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_kernel     <= KSEL_PASS;
            r_lb_sel     <= 1'b0;
            r_frame_done <= 1'b0;
            r_sync_err   <= 1'b0;
        end else begin
            r_frame_done <= (r_state == ST_DONE);
            r_sync_err   <= w_restart;
            if (w_start) begin
                r_kernel <= sw_to_kernel(SW);
            end
            if (w_restart) begin
                r_lb_sel <= 1'b0;
            end else if (w_toggle) begin
                r_lb_sel <= ~r_lb_sel;
            end
        end
    end

    assign bus.win_valid  = r_win_valid;
    assign bus.win_x      = r_win_x;
    assign bus.win_y      = r_win_y;
    assign bus.win_border = r_win_border;
    assign kernel_sel     = r_kernel;
    assign lb_sel         = r_lb_sel;
    assign frame_done     = r_frame_done;
    assign sync_err       = r_sync_err;

endmodule
